// File: rtl/icache.sv
// Instruction cache: set-associative, tree-PLRU replacement, single outstanding
// line refill and a set-by-set invalidation sweep for fence.i.
// Hit lookup is combinational, so a hit returns its word in the same cycle.
// Optional build macro ICACHE_PERF_EN adds 64-bit saturating hit/miss counters.
module icache #(
    parameter int LINE_BITS = 256,
    parameter int SETS      = 16,
    parameter int WAYS      = 4
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [63:0]          pc,
    input  logic                 pc_vld,
    input  logic                 stall,
    input  logic                 flush,
    output logic [31:0]          ir,
    output logic                 ir_vld,
    output logic                 busy,
    output logic [63:0]          b_addr,
    output logic                 b_rd,
    input  logic [LINE_BITS-1:0] b_data,
    input  logic                 b_dv
`ifdef ICACHE_PERF_EN
    ,
    output logic [63:0]          hit_cnt,
    output logic [63:0]          miss_cnt
`endif
);

    // Address split and derived widths; a field of width zero is kept at
    // least one bit wide so the declarations stay legal.
    localparam int OFF_BITS = $clog2(LINE_BITS / 8);
    localparam int SET_BITS = $clog2(SETS);
    localparam int SET_W    = (SETS > 1) ? SET_BITS : 1;
    localparam int TAG_BITS = 64 - OFF_BITS - SET_BITS;
    localparam int WORD_W   = OFF_BITS - 2;
    localparam int LVLS     = $clog2(WAYS);
    localparam int WAY_W    = (WAYS > 1) ? LVLS : 1;
    localparam int PLRU_W   = (WAYS > 1) ? WAYS - 1 : 1;

    typedef enum logic [1:0] {
        IDLE,
        REFILL,
        FLUSH
    } state_t;

    state_t state, state_nx;

    // Per-set state that must come out of reset clean.
    logic [WAYS-1:0]      valid [SETS];
    logic [PLRU_W-1:0]    plru  [SETS];

    // NOTE: tag and data arrays carry no reset; a line is only ever read
    // through its valid bit, and leaving them unreset lets them map to RAM.
    logic [TAG_BITS-1:0]  tag_mem  [SETS][WAYS];
    logic [LINE_BITS-1:0] data_mem [SETS][WAYS];

    logic                 flush_pend;
    logic [SET_W-1:0]     flush_idx;

    function automatic logic [SET_W-1:0] addr_set(input logic [63:0] a);
        return SET_W'((a >> OFF_BITS) & 64'(SETS - 1));
    endfunction

    function automatic logic [TAG_BITS-1:0] addr_tag(input logic [63:0] a);
        return TAG_BITS'(a >> (OFF_BITS + SET_BITS));
    endfunction

    function automatic logic [WORD_W-1:0] addr_word(input logic [63:0] a);
        return WORD_W'(a >> 2);
    endfunction

    // Walk the PLRU tree from the root; each node bit points towards the
    // less recently used half (0 = left/lower ways, 1 = right/upper ways).
    function automatic logic [WAY_W-1:0] plru_victim(input logic [PLRU_W-1:0] bits);
        int node;
        node = 1;
        for (int l = 0; l < LVLS; l++) begin
            node = 2 * node + (bits[node-1] ? 1 : 0);
        end
        return WAY_W'(node - WAYS);
    endfunction

    // Mark a way most-recent: every node on its path points away from it.
    function automatic logic [PLRU_W-1:0] plru_touch(input logic [PLRU_W-1:0] bits,
                                                     input logic [WAY_W-1:0]  way);
        logic [PLRU_W-1:0] r;
        int                node;
        logic              dir;
        r    = bits;
        node = 1;
        for (int l = 0; l < LVLS; l++) begin
            dir       = way[LVLS-1-l];
            r[node-1] = ~dir;
            node      = 2 * node + (dir ? 1 : 0);
        end
        return r;
    endfunction

    // Lookup side (current pc) and fill side (latched refill address).
    logic [SET_W-1:0]     pc_set;
    logic [TAG_BITS-1:0]  pc_tag;
    logic [WORD_W-1:0]    pc_word;
    logic [WAYS-1:0]      hit_vec;
    logic                 hit;
    logic [WAY_W-1:0]     hit_way;
    logic [LINE_BITS-1:0] hit_line;

    logic [SET_W-1:0]     fill_set;
    logic [TAG_BITS-1:0]  fill_tag;
    logic [WAY_W-1:0]     victim;
    logic                 fill_go;
    logic                 hit_upd;
    logic                 miss_go;

    assign pc_set   = addr_set(pc);
    assign pc_tag   = addr_tag(pc);
    assign pc_word  = addr_word(pc);
    assign fill_set = addr_set(b_addr);
    assign fill_tag = addr_tag(b_addr);

    // Tag compare across all ways of the indexed set.
    always_comb begin
        // NOTE: every combinational output gets a default before any branch,
        // so no path can leave it unassigned and infer a latch.
        hit_vec = '0;
        hit_way = '0;
        for (int w = 0; w < WAYS; w++) begin
            hit_vec[w] = valid[pc_set][w] && (tag_mem[pc_set][w] == pc_tag);
        end
        for (int w = WAYS - 1; w >= 0; w--) begin
            if (hit_vec[w]) hit_way = WAY_W'(w);
        end
    end

    assign hit      = |hit_vec;
    assign hit_line = data_mem[pc_set][hit_way];
    assign ir       = hit ? hit_line[{pc_word, 5'd0} +: 32] : 32'd0;

    // Victim choice: lowest invalid way first, otherwise the PLRU leaf.
    always_comb begin
        victim = plru_victim(plru[fill_set]);
        for (int w = WAYS - 1; w >= 0; w--) begin
            if (!valid[fill_set][w]) victim = WAY_W'(w);
        end
    end

    // Next-state and FSM-derived outputs.
    always_comb begin
        state_nx = state;
        ir_vld   = 1'b0;
        busy     = 1'b1;
        b_rd     = 1'b0;
        miss_go  = 1'b0;
        fill_go  = 1'b0;
        unique case (state)
            IDLE: begin
                busy   = 1'b0;
                ir_vld = pc_vld && hit;
                if (flush) begin
                    state_nx = FLUSH;
                end else if (pc_vld && !hit && !stall) begin
                    miss_go  = 1'b1;
                    state_nx = REFILL;
                end
            end
            REFILL: begin
                b_rd = 1'b1;
                if (b_dv) begin
                    fill_go  = 1'b1;
                    state_nx = (flush_pend || flush) ? FLUSH : IDLE;
                end
            end
            FLUSH: begin
                if (flush_idx == SET_W'(SETS - 1)) state_nx = IDLE;
            end
            default: state_nx = IDLE;
        endcase
        hit_upd = ir_vld && !stall;
    end

    // Control state, valid bits and PLRU bits.
    always_ff @(posedge clk) begin
        // NOTE: sequential state is assigned non-blocking so every register
        // samples pre-edge values, independent of statement order.
        if (rst) begin
            state      <= IDLE;
            b_addr     <= '0;
            flush_pend <= 1'b0;
            flush_idx  <= '0;
            for (int s = 0; s < SETS; s++) begin
                valid[s] <= '0;
                plru[s]  <= '0;
            end
        end else begin
            state <= state_nx;

            if (miss_go) b_addr <= pc & ~64'(LINE_BITS / 8 - 1);

            // A flush seen mid-refill waits for the line to land first.
            if (fill_go)
                flush_pend <= 1'b0;
            else if (state == REFILL && flush)
                flush_pend <= 1'b1;

            if (hit_upd) plru[pc_set] <= plru_touch(plru[pc_set], hit_way);

            if (fill_go) begin
                valid[fill_set][victim] <= 1'b1;
                plru[fill_set]          <= plru_touch(plru[fill_set], victim);
            end

            if (state == FLUSH) begin
                valid[flush_idx] <= '0;
                plru[flush_idx]  <= '0;
                flush_idx        <= (flush_idx == SET_W'(SETS - 1)) ? '0 : flush_idx + 1'b1;
            end
        end
    end

    // Line storage written on refill completion.
    always_ff @(posedge clk) begin
        if (fill_go) begin
            tag_mem[fill_set][victim]  <= fill_tag;
            data_mem[fill_set][victim] <= b_data;
        end
    end

`ifdef ICACHE_PERF_EN
    // Saturating performance counters.
    always_ff @(posedge clk) begin
        if (rst) begin
            hit_cnt  <= '0;
            miss_cnt <= '0;
        end else begin
            if (hit_upd && hit_cnt != '1) hit_cnt <= hit_cnt + 64'd1;
            if (miss_go && miss_cnt != '1) miss_cnt <= miss_cnt + 64'd1;
        end
    end
`endif

endmodule

// File: tb/tb_icache.sv
// Self-checking bench for icache (LINE_BITS=256, SETS=4, WAYS=2).
// Reference model: per-set LRU queues of resident line addresses plus a map of
// delivered line data; with two ways tree-PLRU is exact LRU.
module tb_icache;

    localparam int LB = 256;
    localparam int NS = 4;
    localparam int NW = 2;

    logic          clk = 1'b0;
    logic          rst;
    logic [63:0]   pc;
    logic          pc_vld, stall, flush;
    logic [31:0]   ir;
    logic          ir_vld, busy, b_rd, b_dv;
    logic [63:0]   b_addr;
    logic [LB-1:0] b_data;
`ifdef ICACHE_PERF_EN
    logic [63:0]   hit_cnt, miss_cnt;
`endif

    always #5 clk = ~clk;

    icache #(.LINE_BITS(LB), .SETS(NS), .WAYS(NW)) dut (
        .clk(clk), .rst(rst), .pc(pc), .pc_vld(pc_vld), .stall(stall),
        .flush(flush), .ir(ir), .ir_vld(ir_vld), .busy(busy),
        .b_addr(b_addr), .b_rd(b_rd), .b_data(b_data), .b_dv(b_dv)
`ifdef ICACHE_PERF_EN
        , .hit_cnt(hit_cnt), .miss_cnt(miss_cnt)
`endif
    );

    int vectors = 0;
    int miscompares = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    // ---------------- reference model ----------------
    typedef enum {M_IDLE, M_REFILL, M_FLUSH} mmode_t;
    mmode_t      m_mode = M_IDLE;
    logic [63:0] lru [NS][$];                 // front = least recent
    logic [LB-1:0] mdata [logic [63:0]];
    logic [63:0] m_addr = 0;
    logic        m_pend = 0;
    int          m_fidx = 0;
    logic        m_known = 0;
    logic [63:0] m_hits = 0, m_misses = 0;

    function automatic int m_set(input logic [63:0] a);
        return int'((a >> 5) & 64'h3);
    endfunction

    function automatic logic [63:0] m_line(input logic [63:0] a);
        return a & ~64'h1f;
    endfunction

    function automatic int m_find(input logic [63:0] a);
        int s;
        s = m_set(a);
        for (int i = 0; i < lru[s].size(); i++)
            if (lru[s][i] == m_line(a)) return i;
        return -1;
    endfunction

    task automatic drive(input logic r, input logic [63:0] a, input logic v, input logic s,
                         input logic f, input logic d, input logic [LB-1:0] data);
        rst = r; pc = a; pc_vld = v; stall = s; flush = f; b_dv = d; b_data = data;
    endtask

    // Compare every output against the model, away from the clock edge.
    task automatic sample();
        int          k, idx;
        logic        h;
        logic [31:0] w;
        logic [LB-1:0] l;
        #1;
        if (!m_known) return;
        k = m_find(pc);
        h = (k >= 0);
        w = 32'd0;
        if (h) begin
            l   = mdata[m_line(pc)];
            idx = int'(pc[4:2]);
            w   = l[idx*32 +: 32];
        end
        check("model_ir_vld", ir_vld, pc_vld && h && m_mode == M_IDLE);
        check("model_ir", ir, w);
        check("model_busy", busy, m_mode != M_IDLE);
        check("model_b_rd", b_rd, m_mode == M_REFILL);
        check("model_b_addr", b_addr, m_addr);
`ifdef ICACHE_PERF_EN
        check("model_hit_cnt", hit_cnt, m_hits);
        check("model_miss_cnt", miss_cnt, m_misses);
`endif
    endtask

    task automatic model_update();
        int   s, k;
        logic h;
        if (rst) begin
            for (int i = 0; i < NS; i++) lru[i].delete();
            m_mode = M_IDLE; m_addr = 0; m_pend = 0; m_fidx = 0;
            m_hits = 0; m_misses = 0; m_known = 1;
            return;
        end
        s = m_set(pc);
        k = m_find(pc);
        h = (k >= 0);
        case (m_mode)
            M_IDLE: begin
                if (pc_vld && h && !stall) begin
                    lru[s].delete(k);
                    lru[s].push_back(m_line(pc));
                    m_hits++;
                end
                if (flush) begin
                    m_mode = M_FLUSH; m_fidx = 0;
                end else if (pc_vld && !h && !stall) begin
                    m_mode = M_REFILL; m_addr = m_line(pc); m_misses++;
                end
            end
            M_REFILL: begin
                if (b_dv) begin
                    s = m_set(m_addr);
                    if (lru[s].size() == NW) void'(lru[s].pop_front());
                    lru[s].push_back(m_addr);
                    mdata[m_addr] = b_data;
                    m_mode = (m_pend || flush) ? M_FLUSH : M_IDLE;
                    m_fidx = 0;
                    m_pend = 0;
                end else if (flush) begin
                    m_pend = 1;
                end
            end
            default: begin
                lru[m_fidx].delete();
                m_fidx++;
                if (m_fidx == NS) m_mode = M_IDLE;
            end
        endcase
    endtask

    task automatic advance();
        @(posedge clk);
        model_update();
        @(negedge clk);
    endtask

    task automatic do_reset();
        drive(1, 0, 0, 0, 0, 0, '0);
        advance();
        advance();
    endtask

    // Miss on addr, one waiting cycle, then deliver data.
    task automatic do_fill(input logic [63:0] a, input logic [LB-1:0] data);
        drive(0, a, 1, 0, 0, 0, '0);
        sample();
        check("fill_miss_ir_vld", ir_vld, 0);
        advance();
        drive(0, a, 1, 0, 0, 0, '0);
        sample();
        check("fill_b_rd", b_rd, 1);
        check("fill_b_addr", b_addr, a & ~64'h1f);
        advance();
        drive(0, a, 1, 0, 0, 1, data);
        sample();
        advance();
    endtask

    function automatic logic [LB-1:0] rnd_line();
        logic [LB-1:0] r;
        for (int i = 0; i < LB / 32; i++) r[i*32 +: 32] = $urandom;
        return r;
    endfunction

    // ---------------- directed table ----------------
    typedef struct {
        logic [63:0]   pc;
        logic          vld, stl, fl, bdv;
        logic [LB-1:0] bdata;
        logic          e_ir_vld;
        logic [31:0]   e_ir;
        logic          e_b_rd, e_busy;
        logic [63:0]   e_b_addr;
    } vec_t;

    vec_t tbl [6];

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [LB-1:0] l1;
        logic [63:0]   rpc;
        int            wait_cnt;
        logic          r, v, s, f, d;
        logic [LB-1:0] data;

        l1 = {32'h77770007, 32'h66660006, 32'h55550005, 32'h44440004,
              32'h33330003, 32'h22220002, 32'h11110001, 32'h00000013};
        tbl[0] = '{64'h1000, 0, 0, 0, 0, '0, 0, 32'h0,        0, 0, 64'h0};
        tbl[1] = '{64'h1000, 1, 0, 0, 0, '0, 0, 32'h0,        0, 0, 64'h0};
        tbl[2] = '{64'h1000, 1, 0, 0, 1, l1, 0, 32'h0,        1, 1, 64'h1000};
        tbl[3] = '{64'h1000, 1, 0, 0, 0, '0, 1, 32'h00000013, 0, 0, 64'h1000};
        tbl[4] = '{64'h101C, 1, 0, 0, 0, '0, 1, 32'h77770007, 0, 0, 64'h1000};
        tbl[5] = '{64'h1004, 1, 1, 0, 0, '0, 1, 32'h11110001, 0, 0, 64'h1000};

        drive(1, 0, 0, 0, 0, 0, '0);
        @(negedge clk);
        do_reset();

        for (int i = 0; i < 6; i++) begin
            drive(0, tbl[i].pc, tbl[i].vld, tbl[i].stl, tbl[i].fl, tbl[i].bdv, tbl[i].bdata);
            sample();
            check($sformatf("tbl%0d_ir_vld", i), ir_vld, tbl[i].e_ir_vld);
            check($sformatf("tbl%0d_ir", i), ir, tbl[i].e_ir);
            check($sformatf("tbl%0d_b_rd", i), b_rd, tbl[i].e_b_rd);
            check($sformatf("tbl%0d_busy", i), busy, tbl[i].e_busy);
            check($sformatf("tbl%0d_b_addr", i), b_addr, tbl[i].e_b_addr);
            advance();
        end
`ifdef ICACHE_PERF_EN
        check("perf_miss_cnt", miss_cnt, 1);
        check("perf_hit_cnt", hit_cnt, 2);
`endif

        // Replacement: 0x1080 is least recent when 0x1100 arrives.
        do_reset();
        do_fill(64'h1000, rnd_line());
        do_fill(64'h1080, rnd_line());
        drive(0, 64'h1000, 1, 0, 0, 0, '0);
        sample();
        check("lru_hit_1000", ir_vld, 1);
        advance();
        do_fill(64'h1100, rnd_line());
        drive(0, 64'h1000, 1, 0, 0, 0, '0);
        sample();
        check("lru_keep_1000", ir_vld, 1);
        advance();
        drive(0, 64'h1080, 1, 0, 0, 0, '0);
        sample();
        check("lru_evict_1080", ir_vld, 0);
        advance();
        drive(0, 64'h1080, 1, 0, 0, 0, '0);
        sample();
        check("lru_refetch_b_rd", b_rd, 1);
        advance();
        drive(0, 64'h1080, 1, 0, 0, 1, rnd_line());
        sample();
        advance();

        // Flush in IDLE: four busy cycles, then everything misses.
        drive(0, 0, 0, 0, 1, 0, '0);
        sample();
        advance();
        for (int i = 0; i < NS; i++) begin
            drive(0, 0, 0, 0, 0, 0, '0);
            sample();
            check($sformatf("flush_busy%0d", i), busy, 1);
            advance();
        end
        drive(0, 64'h1000, 1, 0, 0, 0, '0);
        sample();
        check("flush_done_busy", busy, 0);
        check("flush_miss_1000", ir_vld, 0);
        advance();
        drive(0, 64'h1000, 1, 0, 0, 0, '0);
        sample();
        check("flush_refill_b_rd", b_rd, 1);
        advance();
        drive(0, 64'h1000, 1, 0, 0, 1, rnd_line());
        sample();
        advance();

        // Flush during refill: fill lands, then the sweep runs.
        drive(0, 64'h2000, 1, 0, 0, 0, '0);
        sample();
        advance();
        drive(0, 64'h5000, 1, 0, 1, 0, '0);
        sample();
        check("midfill_b_rd", b_rd, 1);
        check("midfill_b_addr", b_addr, 64'h2000);
        advance();
        drive(0, 64'h5000, 1, 0, 0, 1, rnd_line());
        sample();
        advance();
        for (int i = 0; i < NS; i++) begin
            drive(0, 0, 0, 0, 0, 0, '0);
            sample();
            check($sformatf("midfill_flush_busy%0d", i), busy, 1);
            advance();
        end
        drive(0, 64'h2000, 1, 0, 0, 0, '0);
        sample();
        check("midfill_after_busy", busy, 0);
        check("midfill_2000_miss", ir_vld, 0);
        advance();
        drive(0, 64'h2000, 1, 0, 0, 1, rnd_line());
        sample();
        advance();

        // Reset during refill: request drops, late data ignored.
        drive(0, 64'h3000, 1, 0, 0, 0, '0);
        sample();
        advance();
        drive(1, 64'h3000, 1, 0, 0, 0, '0);
        sample();
        check("rst_refill_b_rd_before", b_rd, 1);
        advance();
        drive(0, 0, 0, 0, 0, 1, rnd_line());
        sample();
        check("rst_refill_b_rd", b_rd, 0);
        check("rst_refill_busy", busy, 0);
        check("rst_refill_b_addr", b_addr, 0);
        advance();
        drive(0, 64'h1000, 1, 0, 0, 0, '0);
        sample();
        check("rst_1000_miss", ir_vld, 0);
        advance();
        drive(0, 64'h1000, 1, 0, 0, 0, '0);
        sample();
        check("rst_1000_b_rd", b_rd, 1);
        check("rst_1000_b_addr", b_addr, 64'h1000);
        advance();
        drive(0, 64'h1000, 1, 0, 0, 1, rnd_line());
        sample();
        advance();

        // Randomized traffic over a small pool of conflicting lines.
        wait_cnt = 0;
        for (int n = 0; n < 3000; n++) begin
            rpc = 64'h4000 + 64'($urandom_range(0, 2)) * 64'h80
                + 64'($urandom_range(0, NS - 1)) * 64'h20
                + 64'($urandom_range(0, 7)) * 64'h4;
            r = ($urandom % 500) == 0;
            v = ($urandom % 4) != 0;
            s = ($urandom % 5) == 0;
            f = ($urandom % 80) == 0;
            data = rnd_line();
            if (m_mode == M_REFILL) begin
                if (wait_cnt == 0) begin
                    d = 1;
                    wait_cnt = $urandom_range(0, 3);
                end else begin
                    d = 0;
                    wait_cnt--;
                end
            end else begin
                d = ($urandom % 25) == 0;
            end
            drive(r, rpc, v, s, f, d, data);
            sample();
            advance();
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
